// File: rtl/whack_pkg.sv
// Shared types for the whack-a-mole round scheduler: hole count, FSM states
// and a helper that sizes the down-counters.
package whack_pkg;

    localparam int unsigned NUM_HOLES = 5;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SHOW,
        GAP,
        DONE
    } sched_state_t;

    // Bits needed to hold n-1 (a counter loaded with n-1 gives an n-cycle window).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mole_round_scheduler_cycle_timer.sv
// cycle_timer: loadable down-counter. Load N-1 and o_expired is high on the
// cycle the count reads 0, giving a window of exactly N enabled cycles.
module cycle_timer
    import whack_pkg::*;
#(
    parameter  int unsigned MAX_COUNT = 2,
    localparam int unsigned W         = cnt_width(MAX_COUNT)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/mole_round_scheduler.sv
// Round sequencer for the whack-a-mole datapath: spawns one mole per round, times the
// show/gap windows, scores hits and ends the game on misses. MOLE_SPEEDUP_EN shrinks the window per hit.
module mole_round_scheduler
    import whack_pkg::*;
#(
    parameter int unsigned NUM_HOLES       = whack_pkg::NUM_HOLES,
    parameter int unsigned SHOW_CYCLES     = 50_000_000,
    parameter int unsigned GAP_CYCLES      = 10_000_000,
    parameter int unsigned MIN_SHOW_CYCLES = 10_000_000,
    parameter int unsigned MAX_MISSES      = 3,
    parameter int unsigned SCORE_W         = 8,
    localparam int unsigned MISS_W         = $clog2(MAX_MISSES + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NUM_HOLES-1:0] i_hit,
    input  logic [NUM_HOLES-1:0] i_gen_moles,
    output logic                 o_gen_en,
    output logic [NUM_HOLES-1:0] o_moles,
    output logic [SCORE_W-1:0]   o_score,
    output logic [MISS_W-1:0]    o_misses,
    output logic                 o_round_active,
    output logic                 o_game_over
);

    // Show timer is sized for the largest window it can ever be loaded with.
    localparam int unsigned SHOW_MAX = (MIN_SHOW_CYCLES > SHOW_CYCLES) ? MIN_SHOW_CYCLES : SHOW_CYCLES;
    localparam int unsigned SHOW_W   = cnt_width(SHOW_MAX);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYCLES);

    localparam logic [SHOW_W-1:0] SHOW_LOAD = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MAX_MISSES);

    sched_state_t         r_state;
    logic                 r_gen_en;
    logic [NUM_HOLES-1:0] r_moles;
    logic [NUM_HOLES-1:0] r_mole_q;
    logic [NUM_HOLES-1:0] r_hit_q;
    logic [SCORE_W-1:0]   r_score;
    logic [MISS_W-1:0]    r_misses;
    logic                 r_round_active;
    logic                 r_game_over;

    logic [NUM_HOLES-1:0] w_hit_edge;
    logic                 w_gen_onehot;
    logic                 w_good_hit;
    logic                 w_new_game;
    logic                 w_show_load_en;
    logic                 w_show_exp;
    logic                 w_gap_load_en;
    logic                 w_gap_exp;
    logic [MISS_W-1:0]    w_miss_next;
    logic [SHOW_W-1:0]    w_show_load;

    assign w_hit_edge     = i_hit & ~r_hit_q;
    assign w_gen_onehot   = (i_gen_moles != '0) && ((i_gen_moles & (i_gen_moles - 1'b1)) == '0);
    assign w_good_hit     = (r_state == SHOW) && ((w_hit_edge & r_mole_q) != '0);
    assign w_new_game     = ((r_state == IDLE) || (r_state == DONE)) && i_start;
    assign w_show_load_en = (r_state == SPAWN) && w_gen_onehot;
    assign w_gap_load_en  = (r_state == SHOW) && (w_good_hit || w_show_exp);
    assign w_miss_next    = r_misses + 1'b1;

`ifdef MOLE_SPEEDUP_EN
    localparam logic [SHOW_W-1:0] STEP     = SHOW_W'(SHOW_CYCLES / 8);
    localparam logic [SHOW_W-1:0] MIN_LOAD = SHOW_W'(MIN_SHOW_CYCLES - 1);

    logic [SHOW_W-1:0] r_show_load;

    // Each correct hit trims the next window, never below the floor.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_show_load <= SHOW_LOAD;
        end else if (w_new_game) begin
            r_show_load <= SHOW_LOAD;
        end else if (w_good_hit) begin
            r_show_load <= (r_show_load >= MIN_LOAD + STEP) ? (r_show_load - STEP) : MIN_LOAD;
        end
    end

    assign w_show_load = r_show_load;
`else
    assign w_show_load = SHOW_LOAD;
`endif

    cycle_timer #(.MAX_COUNT(SHOW_MAX)) u_show_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_show_load_en),
        .i_value   (w_show_load),
        .i_en      (r_state == SHOW),
        .o_expired (w_show_exp)
    );

    cycle_timer #(.MAX_COUNT(GAP_CYCLES)) u_gap_timer (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_gap_load_en),
        .i_value   (GAP_LOAD),
        .i_en      (r_state == GAP),
        .o_expired (w_gap_exp)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_hit_q <= '0;
        else         r_hit_q <= i_hit;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_gen_en       <= 1'b0;
            r_moles        <= '0;
            r_mole_q       <= '0;
            r_score        <= '0;
            r_misses       <= '0;
            r_round_active <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state     <= SPAWN;
                        r_gen_en    <= 1'b1;
                        r_game_over <= 1'b0;
                        r_score     <= '0;
                        r_misses    <= '0;
                    end
                end
                SPAWN: begin
                    // Zero or multi-hot generator output is not a mole; keep waiting.
                    if (w_gen_onehot) begin
                        r_state        <= SHOW;
                        r_gen_en       <= 1'b0;
                        r_mole_q       <= i_gen_moles;
                        r_moles        <= i_gen_moles;
                        r_round_active <= 1'b1;
                    end
                end
                SHOW: begin
                    if (w_good_hit) begin
                        if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
                        r_state        <= GAP;
                        r_moles        <= '0;
                        r_round_active <= 1'b0;
                    end else if (w_show_exp) begin
                        r_misses       <= w_miss_next;
                        r_moles        <= '0;
                        r_round_active <= 1'b0;
                        if (w_miss_next == MISS_MAX) begin
                            r_state     <= DONE;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_gap_exp) begin
                        r_state  <= SPAWN;
                        r_gen_en <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_gen_en       = r_gen_en;
    assign o_moles        = r_moles;
    assign o_score        = r_score;
    assign o_misses       = r_misses;
    assign o_round_active = r_round_active;
    assign o_game_over    = r_game_over;

endmodule
